sync_fifo_param: RTL

- Single-clock, parametrised successor to the team's dual-clock FIFO, for buffering within one clock domain.
- Adds programmable almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow error flags and a selectable first-word-fall-through (FWFT) read mode.
- Keeps the winc/rinc/wdata/rdata/wfull/rempty handshake used by the rest of the FIFO family.

---
 rtl/sync_fifo_param.sv | 139 +++++++++++++
 1 files changed

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, sticky overflow/underflow flags and a
// selectable standard (registered) or first-word-fall-through read port.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   winc, wdata      write request / data
//   wfull            count == DEPTH
//   walmost_full     count >= AF_LEVEL
//   rinc             read request (standard) or pop (FWFT)
//   rdata, rvalid    read data and its qualifier
//   rempty           count == 0
//   ralmost_empty    count <= AE_LEVEL
//   count            occupancy 0..DEPTH
//   overflow         sticky: write attempted while full
//   underflow        sticky: read attempted while empty
//   clr_err          synchronous clear of overflow/underflow
module sync_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT       = 0,
  parameter int AF_LEVEL   = 14,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  winc,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  wfull,
  output logic                  walmost_full,
  input  logic                  rinc,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  rempty,
  output logic                  ralmost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] AF_C = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_C = (ADDR_WIDTH+1)'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH:0] wptr, rptr, wptr_nxt, rptr_nxt, count_nxt;
  logic                wr_en, rd_en;

  // Accept decisions look only at current registered flags, so a blocked
  // write is never rescued by a same-cycle read (and vice versa).
  assign wr_en = winc & ~wfull;
  assign rd_en = rinc & ~rempty;

  always_comb begin
    wptr_nxt  = wptr + (ADDR_WIDTH+1)'(wr_en);
    rptr_nxt  = rptr + (ADDR_WIDTH+1)'(rd_en);
    count_nxt = count;
    case ({wr_en, rd_en})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Pointers, occupancy and flags. Flags are registered from next state so
  // they line up with count in the cycle after the causing edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr          <= '0;
      rptr          <= '0;
      count         <= '0;
      wfull         <= 1'b0;
      rempty        <= 1'b1;
      walmost_full  <= 1'b0;
      ralmost_empty <= 1'b1;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
    end else begin
      wptr          <= wptr_nxt;
      rptr          <= rptr_nxt;
      count         <= count_nxt;
      // full: same address, opposite wrap bit; empty: identical pointers
      wfull         <= (wptr_nxt[ADDR_WIDTH-1:0] == rptr_nxt[ADDR_WIDTH-1:0]) &&
                       (wptr_nxt[ADDR_WIDTH] != rptr_nxt[ADDR_WIDTH]);
      rempty        <= (wptr_nxt == rptr_nxt);
      walmost_full  <= (count_nxt >= AF_C);
      ralmost_empty <= (count_nxt <= AE_C);
      // clear wins over a new error in the same cycle
      if (clr_err) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        if (winc && wfull)  overflow  <= 1'b1;
        if (rinc && rempty) underflow <= 1'b1;
      end
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[ADDR_WIDTH-1:0]] <= wdata;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      logic [DATA_WIDTH-1:0] head_nxt;

      // The next head is in memory unless it is the very slot being written
      // this edge (write into empty, or write+pop at count 1); forward wdata.
      always_comb begin
        head_nxt = mem[rptr_nxt[ADDR_WIDTH-1:0]];
        if (wr_en && (wptr == rptr_nxt)) head_nxt = wdata;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rdata  <= '0;
          rvalid <= 1'b0;
        end else begin
          rvalid <= (count_nxt != '0);
          if (count_nxt != '0) rdata <= head_nxt;
        end
      end
    end else begin : g_std
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rdata  <= '0;
          rvalid <= 1'b0;
        end else begin
          rvalid <= rd_en;
          if (rd_en) rdata <= mem[rptr[ADDR_WIDTH-1:0]];
        end
      end
    end
  endgenerate

endmodule
